prog_loader: RTL and testbench
==============================

# prog_loader

Parametrised program loader and run monitor for the CPU. It accepts a length-prefixed word stream, writes the words into instruction memory from `BASE_ADDR` upward, and holds the CPU in reset until the load is complete. It then releases the CPU, counts execution cycles until the halt indication, and reports done, error and cycle count. It replaces bench-side direct memory pokes with a synthesizable boot path usable on the board.

## Interface
Parameters:
- `WORD_W`, 16: instruction/stream word width.
- `ADDR_W`, 8: instruction memory address width; capacity 2^ADDR_W words.
- `BASE_ADDR`, 0: address of the first loaded word.
- `CYC_W`, 32: cycle counter width.
- `TIMEOUT`, 0: run-cycle limit; 0 disables the timeout.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  stream word valid.
- `in_ready`  out  1  loader can accept a word.
- `in_data`  in  WORD_W  stream word.
- `mem_we`  out  1  instruction memory write strobe.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  WORD_W  write data.
- `cpu_rst`  out  1  CPU reset; high in every state except RUN.
- `do_halt`  in  1  CPU halt indication; a 1→0 transition means halt.
- `busy`  out  1  state is LEN, LOAD, CHECK or RUN.
- `done`  out  1  sticky; the program halted normally.
- `err_code`  out  2  sticky error code: 0 none, 1 length overflow, 2 checksum, 3 timeout.
- `cycles`  out  CYC_W  run cycle count; frozen after DONE or ERR.

## Operation
- A word is accepted (handshake) on a rising edge where `in_valid && in_ready`.
- `in_ready` is combinational from state: 1 in IDLE, LOAD and CHECK; 0 otherwise.
- **IDLE:** the first accepted word is the length N (unsigned, WORD_W bits).
  - If `BASE_ADDR + N > 2^ADDR_W`: go to ERR with code 1. No write occurs.
  - If N = 0: go to CHECK if the macro is defined, else RUN.
  - Otherwise: go to LOAD with the word counter at 0.
- **LOAD:** each accepted word is written to `BASE_ADDR + counter`, then the counter increments.
  - After the Nth word: go to CHECK if the macro is defined, else RUN.
  - Gaps in `in_valid` stall the load without side effects.
- **RUN:** `cpu_rst` = 0 and `cycles` increments by 1 each cycle, saturating at all-ones.
  - `do_halt` is registered every cycle into `halt_q` (reset value 0).
  - Halt is detected when `halt_q == 1 && do_halt == 0` while in RUN. Then go to DONE; `done` = 1.
  - If `TIMEOUT != 0` and `cycles` reaches TIMEOUT before halt is detected: go to ERR with code 3.
  - If halt and timeout occur in the same cycle, halt wins.
- **DONE / ERR:** terminal. `cpu_rst` = 1, `in_ready` = 0, outputs hold until `rst`.
- Address arithmetic is ADDR_W bits. The overflow check is done at full width, so wrap-around never occurs.

## Timing
- Reset values: `mem_we` 0, `mem_addr` `BASE_ADDR`, `mem_wdata` 0, `cpu_rst` 1, `busy` 0, `done` 0, `err_code` 0, `cycles` 0. State is IDLE and `in_ready` is 1 in the first cycle after `rst` falls.
- All outputs except `in_ready` are registered.
- Write latency: a word accepted at edge k drives `mem_we`/`mem_addr`/`mem_wdata` during cycle k..k+1. The memory captures the write at edge k+1.
- Last word (or checksum) accepted at edge k:
  - the state is RUN from edge k+1;
  - `cpu_rst` falls at edge k+2, after the last write has landed;
  - `cycles` counts edges with `cpu_rst == 0`.
- Halt detected at edge h: `done` and frozen `cycles` are visible after edge h.
- `rst` high at any edge, in any state, takes priority. The block returns to the reset values, the current load is abandoned, and the next load restarts at `BASE_ADDR`.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - After the N program words (also when N = 0), state CHECK accepts one more word.
  - That word must equal the sum of the N words mod 2^WORD_W.
  - Match: go to RUN. Mismatch: go to ERR with code 2; the CPU stays in reset.
  - No write is issued for the checksum word.
- Not defined: the CHECK state does not exist, LOAD goes directly to RUN, and `err_code` 2 never occurs.

## Test plan
- **Fib load:** stream N=12, then the 12 fib program words with halt 16'hFFFF at address 11; model the CPU, dropping `do_halt` 40 cycles after release. Required: memory[0..11] matches the stream, `cpu_rst` falls 2 cycles after the last handshake, `done` = 1, `err_code` = 0, `cycles` = 40.
- **Backpressure:** N=4 with `in_valid` toggling every cycle. Required: exactly 4 `mem_we` pulses at addresses 0, 1, 2, 3 in order, and no write on non-handshake cycles.
- **Overflow:** `ADDR_W=4`, N=17. Required: `err_code` = 1 the edge after the length handshake, no `mem_we`, `cpu_rst` stays 1, `in_ready` = 0.
- **Timeout:** `TIMEOUT=100`, N=1, `do_halt` held high. Required: `err_code` = 3 with `cycles` = 100, `cpu_rst` reasserted, `done` = 0.
- **Reset mid-load:** N=8, `rst` after 5 words. Required: all reset values next cycle; a fresh N=2 load writes to addresses 0 and 1.
- **Checksum (macro on):** words 1, 2, 3 with checksum 6 → RUN. Same words with checksum 7 → `err_code` = 2, `cpu_rst` stays 1.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader and CPU run monitor.
// Takes a length-prefixed word stream, writes the words into instruction
// memory from BASE_ADDR upward and holds the CPU in reset while loading.
// It then releases the CPU and counts run cycles until the halt indication
// (a 1->0 edge on do_halt), reporting done, error code and cycle count.
//
// Optional feature macro: PROG_LOADER_CHECKSUM_EN
//   When defined, one extra checksum word (sum of the program words
//   mod 2^WORD_W) follows the program and must match before the CPU runs.
//
// Ports:
//   CLK        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   stream word valid
//   in_ready   out  loader can accept a word (combinational from state)
//   in_data    in   stream word
//   mem_we     out  instruction memory write strobe
//   mem_addr   out  instruction memory write address
//   mem_wdata  out  instruction memory write data
//   cpu_rst    out  CPU reset, low only while running
//   do_halt    in   CPU halt indication (falling edge = halt)
//   busy       out  loading, checking or running
//   done       out  sticky, program halted normally
//   err_code   out  sticky: 0 none, 1 length overflow, 2 checksum, 3 timeout
//   cycles     out  run cycle count, frozen once done or errored
module prog_loader #(
    parameter int unsigned WORD_W    = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned CYC_W     = 32,
    parameter int unsigned TIMEOUT   = 0
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_rst,
    input  logic              do_halt,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [CYC_W-1:0]  cycles
);

    // Width wide enough to hold BASE_ADDR + N and 2^ADDR_W without wrapping.
    localparam int unsigned CHK_W = ((WORD_W > ADDR_W) ? WORD_W : ADDR_W) + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_len;
    logic [WORD_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   r_addr;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0]   r_sum;
`endif
    logic                r_halt_q;
    logic                r_run_d;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [WORD_W-1:0]   r_mem_wdata;
    logic                r_cpu_rst;
    logic                r_busy;
    logic                r_done;
    logic [1:0]          r_err;
    logic [CYC_W-1:0]    r_cycles;

    logic                w_ready;
    logic                w_hs;
    logic [CHK_W-1:0]    w_len_end;
    logic [CHK_W-1:0]    w_cap;
    logic                w_len_ovf;
    logic                w_last;
    logic                w_halt;
    logic                w_tmo;
    logic                w_cyc_sat;

    // Ready depends only on the current state.
    always_comb begin
        w_ready = 1'b0;
        if (r_state == S_IDLE || r_state == S_LOAD)
            w_ready = 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
        if (r_state == S_CHECK)
            w_ready = 1'b1;
`endif
    end

    assign w_hs      = in_valid && w_ready;
    assign w_len_end = CHK_W'(BASE_ADDR) + CHK_W'(in_data);
    assign w_cap     = CHK_W'(1) << ADDR_W;
    assign w_len_ovf = (w_len_end > w_cap);
    assign w_last    = (r_cnt == (r_len - WORD_W'(1)));
    assign w_halt    = r_halt_q && !do_halt;
    assign w_tmo     = (TIMEOUT != 0) && (r_cycles == CYC_W'(TIMEOUT));
    assign w_cyc_sat = &r_cycles;

    // Loader / run-monitor FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_cnt       <= '0;
            r_addr      <= ADDR_W'(BASE_ADDR);
`ifdef PROG_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
            r_halt_q    <= 1'b0;
            r_run_d     <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_W'(BASE_ADDR);
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 2'd0;
            r_cycles    <= '0;
        end else begin
            r_halt_q <= do_halt;
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        r_len  <= in_data;
                        r_cnt  <= '0;
                        r_addr <= ADDR_W'(BASE_ADDR);
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum  <= '0;
`endif
                        if (w_len_ovf) begin
                            r_state <= S_ERR;
                            r_err   <= 2'd1;
                        end else if (in_data == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state <= S_CHECK;
`else
                            r_state <= S_RUN;
`endif
                            r_busy  <= 1'b1;
                        end else begin
                            r_state <= S_LOAD;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= in_data;
                        r_addr      <= r_addr + ADDR_W'(1);
                        r_cnt       <= r_cnt + WORD_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_sum       <= r_sum + in_data;
                        if (w_last)
                            r_state <= S_CHECK;
`else
                        if (w_last)
                            r_state <= S_RUN;
`endif
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_hs) begin
                        if (in_data == r_sum) begin
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_ERR;
                            r_err   <= 2'd2;
                            r_busy  <= 1'b0;
                        end
                    end
                end
`endif
                S_RUN: begin
                    if (w_halt) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_tmo) begin
                        r_state   <= S_ERR;
                        r_err     <= 2'd3;
                        r_cpu_rst <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        // First RUN cycle keeps the CPU in reset so the last write lands first.
                        r_run_d <= 1'b1;
                        if (r_run_d)
                            r_cpu_rst <= 1'b0;
                        if (!r_cpu_rst && !w_cyc_sat)
                            r_cycles <= r_cycles + CYC_W'(1);
                    end
                end
                default: begin
                    // DONE and ERR are terminal until reset.
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err_code  = r_err;
    assign cycles    = r_cycles;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: instance A uses default parameters,
// instance B uses ADDR_W=4 and TIMEOUT=100.
module tb_prog_loader;

    logic        clk;

    logic        a_rst, a_in_valid, a_in_ready, a_mem_we, a_cpu_rst, a_do_halt;
    logic        a_busy, a_done;
    logic [15:0] a_in_data, a_mem_wdata;
    logic [7:0]  a_mem_addr;
    logic [1:0]  a_err;
    logic [31:0] a_cycles;

    logic        b_rst, b_in_valid, b_in_ready, b_mem_we, b_cpu_rst, b_do_halt;
    logic        b_busy, b_done;
    logic [15:0] b_in_data, b_mem_wdata;
    logic [3:0]  b_mem_addr;
    logic [1:0]  b_err;
    logic [31:0] b_cycles;

    int          n_cmp;
    int          n_fail;

    logic [15:0] mem [0:255];
    logic [7:0]  wr_addr [0:63];
    int          wr_cnt;

    logic [15:0] fib [0:11];
    logic [15:0] sum;
    int          base;

    prog_loader u_a (
        .CLK(clk), .rst(a_rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .cpu_rst(a_cpu_rst), .do_halt(a_do_halt),
        .busy(a_busy), .done(a_done), .err_code(a_err), .cycles(a_cycles)
    );

    prog_loader #(.ADDR_W(4), .TIMEOUT(100)) u_b (
        .CLK(clk), .rst(b_rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .cpu_rst(b_cpu_rst), .do_halt(b_do_halt),
        .busy(b_busy), .done(b_done), .err_code(b_err), .cycles(b_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory and write log for instance A.
    initial wr_cnt = 0;
    always @(posedge clk) begin
        if (a_mem_we) begin
            mem[a_mem_addr]  <= a_mem_wdata;
            wr_addr[wr_cnt]  <= a_mem_addr;
            wr_cnt           <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [15:0] w);
        a_in_valid = 1'b1;
        a_in_data  = w;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [15:0] w);
        b_in_valid = 1'b1;
        b_in_data  = w;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic reset_a;
        a_rst = 1'b1;
        step();
        a_rst = 1'b0;
    endtask

    task automatic reset_b;
        b_rst = 1'b1;
        step();
        b_rst = 1'b0;
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_we"},    32'(a_mem_we),    32'd0);
        check({tag, "_addr"},  32'(a_mem_addr),  32'd0);
        check({tag, "_wdata"}, 32'(a_mem_wdata), 32'd0);
        check({tag, "_cpurst"},32'(a_cpu_rst),   32'd1);
        check({tag, "_busy"},  32'(a_busy),      32'd0);
        check({tag, "_done"},  32'(a_done),      32'd0);
        check({tag, "_err"},   32'(a_err),       32'd0);
        check({tag, "_cyc"},   a_cycles,         32'd0);
        check({tag, "_ready"}, 32'(a_in_ready),  32'd1);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        fib[0]  = 16'h1001; fib[1]  = 16'h1102; fib[2]  = 16'h2013; fib[3]  = 16'h3124;
        fib[4]  = 16'h4235; fib[5]  = 16'h5346; fib[6]  = 16'h6457; fib[7]  = 16'h7568;
        fib[8]  = 16'h8679; fib[9]  = 16'h978A; fib[10] = 16'hA89B; fib[11] = 16'hFFFF;
        a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_do_halt = 1'b0;
        b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_do_halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_a_reset("rst0");
        a_rst = 1'b0; b_rst = 1'b0;
        step();
        check("idle_ready", 32'(a_in_ready), 32'd1);

        // Fib load and run with halt 40 cycles after release.
        a_do_halt = 1'b1;
        sum = '0;
        send_a(16'd12);
        check("fib_busy", 32'(a_busy), 32'd1);
        for (int i = 0; i < 12; i++) begin
            send_a(fib[i]);
            sum = sum + fib[i];
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        send_a(sum);
`endif
        check("fib_rel_k0", 32'(a_cpu_rst), 32'd1);
        step();
        check("fib_rel_k1", 32'(a_cpu_rst), 32'd1);
        step();
        check("fib_rel_k2", 32'(a_cpu_rst), 32'd0);
        check("fib_cyc0",   a_cycles,       32'd0);
        for (int i = 0; i < 12; i++)
            check("fib_mem", 32'(mem[i]), 32'(fib[i]));
        repeat (40) @(posedge clk);
        #1;
        check("fib_cyc40",  a_cycles,     32'd40);
        check("fib_notdone",32'(a_done),  32'd0);
        a_do_halt = 1'b0;
        step();
        check("fib_done",   32'(a_done),    32'd1);
        check("fib_err",    32'(a_err),     32'd0);
        check("fib_cyc",    a_cycles,       32'd40);
        check("fib_cpurst", 32'(a_cpu_rst), 32'd1);
        check("fib_busy0",  32'(a_busy),    32'd0);
        check("fib_ready0", 32'(a_in_ready),32'd0);
        step();
        check("fib_frozen", a_cycles,       32'd40);

        // Backpressure: in_valid gaps between every word.
        reset_a();
        base = wr_cnt;
        sum = '0;
        send_a(16'd4);
        for (int i = 0; i < 4; i++) begin
            step();
            send_a(16'h00A0 + 16'(i));
            sum = sum + 16'h00A0 + 16'(i);
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        step();
        send_a(sum);
`endif
        step();
        check("bp_count", 32'(wr_cnt - base), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("bp_addr", 32'(wr_addr[base + i]), 32'(i));
            check("bp_data", 32'(mem[i]), 32'h00A0 + 32'(i));
        end

        // Reset in the middle of a load, then a fresh load.
        reset_a();
        send_a(16'd8);
        for (int i = 0; i < 5; i++)
            send_a(16'h5A50 + 16'(i));
        a_rst = 1'b1;
        step();
        check_a_reset("midrst");
        a_rst = 1'b0;
        base = wr_cnt;
        send_a(16'd2);
        send_a(16'hC001);
        send_a(16'hC002);
        step();
        check("fresh_count", 32'(wr_cnt - base),       32'd2);
        check("fresh_addr0", 32'(wr_addr[base]),       32'd0);
        check("fresh_addr1", 32'(wr_addr[base + 1]),   32'd1);
        check("fresh_data1", 32'(mem[1]),              32'hC002);

        // Empty program: N = 0 goes straight to the run phase.
        reset_a();
        a_do_halt = 1'b1;
        send_a(16'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_a(16'd0);
`endif
        check("n0_busy",  32'(a_busy),    32'd1);
        check("n0_rst_k0",32'(a_cpu_rst), 32'd1);
        step();
        check("n0_rst_k1",32'(a_cpu_rst), 32'd1);
        step();
        check("n0_rst_k2",32'(a_cpu_rst), 32'd0);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Checksum match then mismatch.
        reset_a();
        send_a(16'd3); send_a(16'd1); send_a(16'd2); send_a(16'd3);
        send_a(16'd6);
        step();
        step();
        check("cs_ok_rst", 32'(a_cpu_rst), 32'd0);
        check("cs_ok_err", 32'(a_err),     32'd0);
        reset_a();
        send_a(16'd3); send_a(16'd1); send_a(16'd2); send_a(16'd3);
        send_a(16'd7);
        check("cs_bad_err", 32'(a_err),     32'd2);
        check("cs_bad_rst", 32'(a_cpu_rst), 32'd1);
        step();
        step();
        check("cs_bad_rst2",32'(a_cpu_rst), 32'd1);
`endif

        // Overflow on the 16-word instance.
        send_b(16'd17);
        check("ovf_err",   32'(b_err),      32'd1);
        check("ovf_we",    32'(b_mem_we),   32'd0);
        check("ovf_rst",   32'(b_cpu_rst),  32'd1);
        check("ovf_ready", 32'(b_in_ready), 32'd0);
        check("ovf_busy",  32'(b_busy),     32'd0);
        step();
        check("ovf_we2",   32'(b_mem_we),   32'd0);
        check("ovf_err2",  32'(b_err),      32'd1);

        // Exactly full memory is accepted.
        reset_b();
        send_b(16'd16);
        check("full_err",  32'(b_err),  32'd0);
        check("full_busy", 32'(b_busy), 32'd1);

        // Timeout with do_halt held high.
        reset_b();
        b_do_halt = 1'b1;
        send_b(16'd1);
        send_b(16'h1234);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_b(16'h1234);
`endif
        repeat (102) @(posedge clk);
        #1;
        check("tmo_pre_err", 32'(b_err),     32'd0);
        check("tmo_pre_cyc", b_cycles,       32'd100);
        check("tmo_pre_rst", 32'(b_cpu_rst), 32'd0);
        step();
        check("tmo_err",  32'(b_err),     32'd3);
        check("tmo_cyc",  b_cycles,       32'd100);
        check("tmo_rst",  32'(b_cpu_rst), 32'd1);
        check("tmo_done", 32'(b_done),    32'd0);
        step();
        check("tmo_cyc2", b_cycles,       32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
